// File: rtl/jk_ff_exerciser_if.sv
// Pin bundle between the JK exerciser, the flip-flop under test and the board-level start/status.
// Latency: none, wiring only.
// Backpressure: none; every signal is a plain level.
interface jk_ff_exerciser_if;
  logic       Start;
  logic       Q_in;
  logic       Qn_in;
  logic       nPr_out;
  logic       nClr_out;
  logic       J_out;
  logic       K_out;
  logic       FF_Clk_out;
  logic       Busy;
  logic       Done;
  logic       Pass;
  logic [3:0] ErrCount;
  logic [3:0] FailStep;
  logic [3:0] StepIdx;

  // Exerciser side: drives the flip-flop pins and status, reads Start and Q/Qn.
  modport master (
    input  Start, Q_in, Qn_in,
    output nPr_out, nClr_out, J_out, K_out, FF_Clk_out,
    output Busy, Done, Pass, ErrCount, FailStep, StepIdx
  );

  // Board/flip-flop side: the mirror image.
  modport slave (
    output Start, Q_in, Qn_in,
    input  nPr_out, nClr_out, J_out, K_out, FF_Clk_out,
    input  Busy, Done, Pass, ErrCount, FailStep, StepIdx
  );
endinterface

// File: rtl/jk_ff_exerciser.sv
// Purpose: drives a fixed ten-step clear/preset/hold/reset/set/toggle sequence onto a JK flip-flop and checks Q/Qn after each step.
// Latency: Start sampled at edge N -> SETUP from N+1; each step is 2*SETTLE_CYCLES+PULSE_CYCLES+1 cycles; Done at N+1+10*step.
// Backpressure: none; Start edges while Busy are ignored. Define JK_EXER_SYNC_EN to synchronize Q_in/Qn_in (needs SETTLE_CYCLES >= 3).
module jk_ff_exerciser #(
  parameter int SETTLE_CYCLES = 4,
  parameter int PULSE_CYCLES  = 4
) (
  input  logic              Clk,
  input  logic              nReset,
  jk_ff_exerciser_if.master io
);

  localparam int CNT_MAX = (SETTLE_CYCLES > PULSE_CYCLES) ? SETTLE_CYCLES : PULSE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [3:0]       LAST_STEP   = 4'd9;
  localparam logic [3:0]       NO_FAIL     = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_CHECK,
    S_DONE
  } state_t;

  // Step table: J and K for each step (steps 0/1 are async pulses with J=K=0).
  function automatic logic step_j(input logic [3:0] s);
    case (s)
      4'd5, 4'd6, 4'd7, 4'd8, 4'd9: step_j = 1'b1;
      default:                      step_j = 1'b0;
    endcase
  endfunction

  function automatic logic step_k(input logic [3:0] s);
    case (s)
      4'd3, 4'd6, 4'd7, 4'd8: step_k = 1'b1;
      default:                step_k = 1'b0;
    endcase
  endfunction

  // Expected Q after each step.
  function automatic logic step_exp_q(input logic [3:0] s);
    case (s)
      4'd1, 4'd2, 4'd5, 4'd7, 4'd9: step_exp_q = 1'b1;
      default:                      step_exp_q = 1'b0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Start edge detection. The first flop registers the pin, the edge is taken
  // between the two registered copies, so a start seen at edge N acts at N+1.
  // ---------------------------------------------------------------------------
  logic start_q, start_d;
  logic start_prev_q, start_prev_d;
  logic start_acc;

  // Next values of the start history.
  always_comb begin
    start_d      = io.Start;
    start_prev_d = start_q;
  end

  // Start history registers.
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      start_q      <= start_d;
      start_prev_q <= start_prev_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Q/Qn into the comparator, optionally through a 2-flop synchronizer. The
  // HOLD phase is long enough for the synchronized copy to settle before CHECK.
  // ---------------------------------------------------------------------------
  logic q_cmp;
  logic qn_cmp;

`ifdef JK_EXER_SYNC_EN
  logic q_s1_q, q_s1_d, q_s2_q, q_s2_d;
  logic qn_s1_q, qn_s1_d, qn_s2_q, qn_s2_d;

  // Synchronizer shift.
  always_comb begin
    q_s1_d  = io.Q_in;
    q_s2_d  = q_s1_q;
    qn_s1_d = io.Qn_in;
    qn_s2_d = qn_s1_q;
  end

  // Synchronizer registers.
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      q_s1_q  <= 1'b0;
      q_s2_q  <= 1'b0;
      qn_s1_q <= 1'b0;
      qn_s2_q <= 1'b0;
    end else begin
      q_s1_q  <= q_s1_d;
      q_s2_q  <= q_s2_d;
      qn_s1_q <= qn_s1_d;
      qn_s2_q <= qn_s2_d;
    end
  end

  assign q_cmp  = q_s2_q;
  assign qn_cmp = qn_s2_q;
`else
  assign q_cmp  = io.Q_in;
  assign qn_cmp = io.Qn_in;
`endif

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       step_q, step_d;

  assign start_acc = start_q & ~start_prev_q & ((state_q == S_IDLE) | (state_q == S_DONE));

  // State register with phase counter and step index.
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

  // Next state: walk SETUP -> PULSE -> HOLD -> CHECK for each of the ten steps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_acc) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          step_d  = '0;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_PULSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CHECK: begin
        cnt_d = '0;
        if (step_q == LAST_STEP) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SETUP;
          step_d  = step_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        step_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs are decoded from the next state and registered, so the flip-flop
  // clock and async pins change only on state boundaries and never glitch.
  // ---------------------------------------------------------------------------
  logic       npr_q, npr_d;
  logic       nclr_q, nclr_d;
  logic       j_q, j_d;
  logic       k_q, k_d;
  logic       ffclk_q, ffclk_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;
  logic [3:0] step_idx_q, step_idx_d;
  logic       mismatch;

  assign mismatch = (q_cmp != step_exp_q(step_q)) | (qn_cmp != ~step_exp_q(step_q));

  // Output decode plus error accounting at the end of CHECK.
  always_comb begin
    npr_d      = 1'b1;
    nclr_d     = 1'b1;
    j_d        = 1'b0;
    k_d        = 1'b0;
    ffclk_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    pass_d     = 1'b0;
    err_d      = err_q;
    fail_d     = fail_q;
    step_idx_d = step_d;

    if (start_acc) begin
      err_d  = 4'd0;
      fail_d = NO_FAIL;
    end

    if ((state_q == S_CHECK) && mismatch) begin
      err_d = (err_q == 4'hF) ? 4'hF : err_q + 4'd1;
      if (fail_q == NO_FAIL) begin
        fail_d = step_q;
      end
    end

    case (state_d)
      S_SETUP, S_PULSE, S_HOLD, S_CHECK: begin
        busy_d = 1'b1;
        j_d    = step_j(step_d);
        k_d    = step_k(step_d);
        if (state_d == S_PULSE) begin
          if (step_d == 4'd0) begin
            nclr_d = 1'b0;
          end else if (step_d == 4'd1) begin
            npr_d = 1'b0;
          end else begin
            ffclk_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        pass_d = (err_d == 4'd0);
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Output and result registers.
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      npr_q      <= 1'b1;
      nclr_q     <= 1'b1;
      j_q        <= 1'b0;
      k_q        <= 1'b0;
      ffclk_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 4'd0;
      fail_q     <= NO_FAIL;
      step_idx_q <= 4'd0;
    end else begin
      npr_q      <= npr_d;
      nclr_q     <= nclr_d;
      j_q        <= j_d;
      k_q        <= k_d;
      ffclk_q    <= ffclk_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      fail_q     <= fail_d;
      step_idx_q <= step_idx_d;
    end
  end

  assign io.nPr_out    = npr_q;
  assign io.nClr_out   = nclr_q;
  assign io.J_out      = j_q;
  assign io.K_out      = k_q;
  assign io.FF_Clk_out = ffclk_q;
  assign io.Busy       = busy_q;
  assign io.Done       = done_q;
  assign io.Pass       = pass_q;
  assign io.ErrCount   = err_q;
  assign io.FailStep   = fail_q;
  assign io.StepIdx    = step_idx_q;

endmodule

// File: tb/tb_jk_ff_exerciser.sv
// Bench for jk_ff_exerciser: behavioural JK flip-flop with selectable faults, a timing-level model of the run, and literal checks.
// Latency: run results expected 131 edges after the sampled Start edge.
// Backpressure: none.
module tb_jk_ff_exerciser;
  localparam int S   = 4;
  localparam int P   = 4;
  localparam int L   = 2 * S + P + 1;
  localparam int RUN = 10 * L;

  logic Clk    = 1'b0;
  logic nReset = 1'b0;

  jk_ff_exerciser_if io();

  jk_ff_exerciser #(.SETTLE_CYCLES(S), .PULSE_CYCLES(P)) dut (
    .Clk    (Clk),
    .nReset (nReset),
    .io     (io)
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  // Flip-flop fault mode: 0 ideal, 1 Q stuck at 0, 2 J=K=1 holds, 3 Qn tied to Q.
  int   mode = 0;
  logic ff_q = 1'b0;

  bit exp_tab [10] = '{0, 1, 1, 0, 0, 1, 0, 1, 0, 1};
  bit j_tab   [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
  bit k_tab   [10] = '{0, 0, 0, 1, 0, 0, 1, 1, 1, 0};

  // Behavioural JK flip-flop with async clear/preset.
  always @(posedge io.FF_Clk_out or negedge io.nClr_out or negedge io.nPr_out) begin
    if (!io.nClr_out)     ff_q <= 1'b0;
    else if (!io.nPr_out) ff_q <= 1'b1;
    else begin
      case ({io.J_out, io.K_out})
        2'b01:   ff_q <= 1'b0;
        2'b10:   ff_q <= 1'b1;
        2'b11:   ff_q <= (mode == 2) ? ff_q : ~ff_q;
        default: ff_q <= ff_q;
      endcase
    end
  end

  assign io.Q_in  = (mode == 1) ? 1'b0 : ff_q;
  assign io.Qn_in = (mode == 3) ? io.Q_in : ~io.Q_in;

  // Does step s report a mismatch for flip-flop fault mode md?
  function automatic bit step_fails(input int md, input int s);
    bit q;
    case (md)
      1: return exp_tab[s];
      2: begin
        q = 1'b0;
        for (int i = 0; i <= s; i++) begin
          if (i == 0)                          q = 1'b0;
          else if (i == 1)                     q = 1'b1;
          else if (j_tab[i] && !k_tab[i])      q = 1'b1;
          else if (!j_tab[i] && k_tab[i])      q = 1'b0;
        end
        return q != exp_tab[s];
      end
      3: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Run-level model: edge count, pending start, run start edge.
  int ecount   = 0;
  bit m_active = 1'b0;
  bit m_pend   = 1'b0;
  bit m_prev   = 1'b0;
  int m_start  = 0;
  int m_mode   = 0;

  always @(posedge Clk) begin
    ecount = ecount + 1;
    if (!nReset) begin
      m_active = 1'b0;
      m_pend   = 1'b0;
      m_prev   = 1'b0;
    end else begin
      if (m_pend) begin
        m_active = 1'b1;
        m_start  = ecount;
        m_mode   = mode;
        m_pend   = 1'b0;
      end
      if (io.Start && !m_prev && !(m_active && (ecount - m_start) < RUN)) m_pend = 1'b1;
      m_prev = io.Start;
    end
  end

  // Expected output vector {nPr,nClr,J,K,FFClk,Busy,Done,Pass,Err,Fail,Step}.
  function automatic logic [19:0] model_out();
    int k, step, ph, c, err, fail;
    logic npr, nclr, j, kk, fclk, busy, done, pass;
    npr = 1; nclr = 1; j = 0; kk = 0; fclk = 0; busy = 0; done = 0; pass = 0;
    err = 0; fail = 15; step = 0;
    if (m_active) begin
      k = ecount - m_start;
      c = (k / L > 10) ? 10 : k / L;
      for (int s = 0; s < c; s++) begin
        if (step_fails(m_mode, s)) begin
          if (err < 15) err++;
          if (fail == 15) fail = s;
        end
      end
      if (k < RUN) begin
        step = k / L;
        ph   = k % L;
        busy = 1;
        j    = j_tab[step];
        kk   = k_tab[step];
        if (ph >= S && ph < S + P) begin
          if (step == 0)      nclr = 0;
          else if (step == 1) npr  = 0;
          else                fclk = 1;
        end
      end else begin
        done = 1;
        pass = (err == 0);
        step = 9;
      end
    end
    return {npr, nclr, j, kk, fclk, busy, done, pass, 4'(err), 4'(fail), 4'(step)};
  endfunction

  bit cmp_en = 1'b0;

  // Cycle-by-cycle compare of every output against the model.
  always @(negedge Clk) begin
    logic [19:0] act, expv;
    if (cmp_en) begin
      expv = model_out();
      act  = {io.nPr_out, io.nClr_out, io.J_out, io.K_out, io.FF_Clk_out, io.Busy,
              io.Done, io.Pass, io.ErrCount, io.FailStep, io.StepIdx};
      checks++;
      if (act !== expv) begin
        failures++;
        $display("FAIL cycle_compare edge=%0d actual=%b expected=%b", ecount, act, expv);
      end
    end
  end

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // One full run; hold_start keeps Start high and re-pulses it while busy.
  task automatic do_run(input int md, input string name, input int e_err,
                        input int e_fail, input int e_pass, input bit hold_start);
    int n_edge, done_edge;
    mode      = md;
    io.Start  = 1'b1;
    n_edge    = ecount + 1;
    done_edge = -1;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (!hold_start && i == 1) io.Start = 1'b0;
      if (hold_start && i == 40) io.Start = 1'b0;
      if (hold_start && i == 43) io.Start = 1'b1;
      if (i >= 2 && io.Done) begin
        done_edge = ecount;
        break;
      end
    end
    check({name, "_done_latency"}, done_edge - n_edge, 131);
    check({name, "_err"},  io.ErrCount, e_err);
    check({name, "_fail"}, io.FailStep, e_fail);
    check({name, "_pass"}, io.Pass, e_pass);
    check({name, "_busy"}, io.Busy, 0);
    io.Start = 1'b0;
    tick(3);
  endtask

  initial begin
    int n_edge;
    io.Start = 1'b0;
    nReset   = 1'b0;
    tick(3);
    check("rst_busy", io.Busy, 0);
    check("rst_done", io.Done, 0);
    check("rst_pass", io.Pass, 0);
    check("rst_err", io.ErrCount, 0);
    check("rst_fail", io.FailStep, 15);
    check("rst_step", io.StepIdx, 0);
    check("rst_pins", {io.nPr_out, io.nClr_out, io.J_out, io.K_out, io.FF_Clk_out}, 5'b11000);
    cmp_en = 1'b1;
    nReset = 1'b1;
    tick(2);

    do_run(0, "ideal",     0, 15, 1, 1'b0);
    do_run(1, "stuck0",    5,  1, 0, 1'b0);
    do_run(2, "no_toggle", 2,  6, 0, 1'b0);
    do_run(3, "qn_tied",  10,  0, 0, 1'b0);

    // Reset in the middle of step 5.
    mode     = 0;
    io.Start = 1'b1;
    n_edge   = ecount + 1;
    tick(2);
    io.Start = 1'b0;
    while (ecount < n_edge + 1 + 5 * L + 2) tick(1);
    check("pre_reset_step", io.StepIdx, 5);
    nReset = 1'b0;
    tick(1);
    check("midrst_busy", io.Busy, 0);
    check("midrst_step", io.StepIdx, 0);
    check("midrst_ffclk", io.FF_Clk_out, 0);
    check("midrst_npr", io.nPr_out, 1);
    check("midrst_nclr", io.nClr_out, 1);
    check("midrst_err", io.ErrCount, 0);
    nReset = 1'b1;
    tick(2);
    do_run(0, "post_reset", 0, 15, 1, 1'b0);

    do_run(0, "held_start", 0, 15, 1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
